// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the HI/LO multiply-divide unit.
interface muldiv_unit_if #(
   parameter int unsigned N = 32
);
   logic         i_start;
   logic [2:0]   i_op;
   logic [N-1:0] i_a;
   logic [N-1:0] i_b;
   logic         i_abort;
   logic [N-1:0] o_hi;
   logic [N-1:0] o_lo;
   logic         o_busy;
   logic         o_done;

   // Core side: issues requests and flushes, observes HI/LO and status.
   modport master (
      output i_start, i_op, i_a, i_b, i_abort,
      input  o_hi, o_lo, o_busy, o_done
   );

   // Unit side.
   modport slave (
      input  i_start, i_op, i_a, i_b, i_abort,
      output o_hi, o_lo, o_busy, o_done
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add over operand magnitudes, divide is restoring; signs
// are re-applied in a single fix-up cycle before writeback.
module muldiv_unit #(
   parameter int unsigned N = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   muldiv_unit_if.slave  bus
);
   localparam int unsigned CW = $clog2(N) + 1;

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_busy;
   logic           w_busy_nxt;
   logic           r_done;
   logic           w_done_nxt;
   logic           w_accept;
   logic           w_step;
   logic           w_wb;

   logic [CW-1:0]  r_cnt;
   logic [N-1:0]   r_acc;      // product high half / partial remainder
   logic [N-1:0]   r_q;        // multiplier shifting out / quotient shifting in
   logic [N-1:0]   r_m;        // multiplicand or divisor magnitude
   logic [N-1:0]   r_a_raw;    // original dividend, returned as HI on divide by zero
   logic           r_is_div;
   logic           r_dz;
   logic           r_neg_lo;
   logic           r_neg_hi;
   logic [N-1:0]   r_hi;
   logic [N-1:0]   r_lo;

   // Request decode and operand magnitudes.
   logic           w_is_iter;
   logic           w_signed;
   logic           w_div;
   logic           w_a_neg;
   logic           w_b_neg;
   logic [N-1:0]   w_a_mag;
   logic [N-1:0]   w_b_mag;
   logic           w_mthi;
   logic           w_mtlo;

   assign w_is_iter = ~bus.i_op[2];
   assign w_signed  = ~bus.i_op[0];
   assign w_div     = bus.i_op[1];
   assign w_a_neg   = w_signed & bus.i_a[N-1];
   assign w_b_neg   = w_signed & bus.i_b[N-1];
   assign w_a_mag   = w_a_neg ? (~bus.i_a + N'(1)) : bus.i_a;
   assign w_b_mag   = w_b_neg ? (~bus.i_b + N'(1)) : bus.i_b;
   assign w_mthi    = (r_state == ST_IDLE) && bus.i_start && (bus.i_op == OP_MTHI);
   assign w_mtlo    = (r_state == ST_IDLE) && bus.i_start && (bus.i_op == OP_MTLO);

   // Next state, status and datapath strobes; Abort outranks the FIX writeback.
   always_comb begin
      w_state_nxt = r_state;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_wb        = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.i_start && w_is_iter) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_RUN;
               w_busy_nxt  = 1'b1;
            end
         end
         ST_RUN: begin
            if (bus.i_abort) begin
               w_state_nxt = ST_IDLE;
               w_busy_nxt  = 1'b0;
            end else begin
               w_step = 1'b1;
               if (r_cnt == CW'(N - 1)) begin
                  w_state_nxt = ST_FIX;
               end
            end
         end
         ST_FIX: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            if (!bus.i_abort) begin
               w_wb       = 1'b1;
               w_done_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and status registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // One radix-2 step: shift-add multiply or restoring divide.
   logic [N:0]     w_sum;
   logic [N:0]     w_shift;
   logic           w_ge;
   logic [N-1:0]   w_diff;

   assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
   assign w_shift = {r_acc, r_q[N-1]};
   assign w_ge    = (w_shift >= {1'b0, r_m});
   assign w_diff  = N'(w_shift - {1'b0, r_m});

   // Sign fix-up and final HI/LO selection.
   logic [2*N-1:0] w_prod;
   logic [2*N-1:0] w_prod_fix;
   logic [N-1:0]   w_quo_fix;
   logic [N-1:0]   w_rem_fix;
   logic [N-1:0]   w_hi_fix;
   logic [N-1:0]   w_lo_fix;

   assign w_prod     = {r_acc, r_q};
   assign w_prod_fix = r_neg_lo ? (~w_prod + (2*N)'(1)) : w_prod;
   assign w_quo_fix  = r_neg_lo ? (~r_q + N'(1)) : r_q;
   assign w_rem_fix  = r_neg_hi ? (~r_acc + N'(1)) : r_acc;

   // Divide by zero bypasses the iterated result entirely.
   always_comb begin
      w_hi_fix = w_prod_fix[2*N-1:N];
      w_lo_fix = w_prod_fix[N-1:0];
      if (r_dz) begin
         w_hi_fix = r_a_raw;
         w_lo_fix = '1;
      end else if (r_is_div) begin
         w_hi_fix = w_rem_fix;
         w_lo_fix = w_quo_fix;
      end
   end

   // Operand latch, iteration datapath, step counter and HI/LO registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_a_raw  <= '0;
         r_is_div <= 1'b0;
         r_dz     <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_a_raw  <= bus.i_a;
            r_is_div <= w_div;
            r_dz     <= w_div && (bus.i_b == '0);
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_div ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_q      <= w_div ? w_a_mag : w_b_mag;
            r_m      <= w_div ? w_b_mag : w_a_mag;
         end else if (w_step) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_is_div) begin
               r_acc <= w_ge ? w_diff : w_shift[N-1:0];
               r_q   <= {r_q[N-2:0], w_ge};
            end else begin
               r_acc <= w_sum[N:1];
               r_q   <= {w_sum[0], r_q[N-1:1]};
            end
         end
         if (w_mthi) begin
            r_hi <= bus.i_a;
         end
         if (w_mtlo) begin
            r_lo <= bus.i_a;
         end
         if (w_wb) begin
            r_hi <= w_hi_fix;
            r_lo <= w_lo_fix;
         end
      end
   end

   assign bus.o_hi   = r_hi;
   assign bus.o_lo   = r_lo;
   assign bus.o_busy = r_busy;
   assign bus.o_done = r_done;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (N=32): directed vectors push expected
// HI/LO and Done cycle; a negedge monitor pops and compares on every Done.
module tb_muldiv_unit;
   localparam int unsigned N = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_RSV   = 3'd6;

   typedef struct {
      logic [N-1:0] hi;
      logic [N-1:0] lo;
      int           cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   muldiv_unit_if #(.N(N)) bus ();

   muldiv_unit #(.N(N)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every Done must match the oldest expected writeback.
   always @(negedge clk) begin
      if (bus.o_done) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got Done at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_hi", 64'(bus.o_hi), 64'(e.hi));
            check("done_lo", 64'(bus.o_lo), 64'(e.lo));
            check("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Present one request for a single edge; optionally expect a writeback 33 edges later.
   task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit push, input logic [N-1:0] ehi, input logic [N-1:0] elo);
      exp_t e;
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_a     = a;
      bus.i_b     = b;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      if (push) begin
         e.hi  = ehi;
         e.lo  = elo;
         e.cyc = cyc + N + 1;
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (bus.o_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.o_busy) begin
         n_tests++;
         n_fail++;
         $display("FAIL busy_timeout: got Busy=1 expected 0 within 100 cycles");
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic run(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] ehi, input logic [N-1:0] elo);
      issue(op, a, b, 1'b1, ehi, elo);
      wait_idle();
   endtask

   initial begin
      cyc         = 0;
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus.i_start = 1'b0;
      bus.i_op    = 3'd0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      bus.i_abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.i_start = 1'b1;
      bus.i_op    = OP_MTHI;
      bus.i_a     = 32'hDEAD_BEEF;
      bus.i_abort = 1'b1;
      @(negedge clk);
      check("rst_hi", 64'(bus.o_hi), 64'h0);
      check("rst_lo", 64'(bus.o_lo), 64'h0);
      check("rst_busy", 64'(bus.o_busy), 64'h0);
      check("rst_done", 64'(bus.o_done), 64'h0);
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      rst = 1'b0;

      // MTHI/MTLO write at the accept edge without Busy.
      issue(OP_MTHI, 32'h0000_1234, '0, 1'b0, '0, '0);
      check("mthi_busy", 64'(bus.o_busy), 64'h0);
      issue(OP_MTLO, 32'h0000_5678, '0, 1'b0, '0, '0);
      check("mtlo_busy", 64'(bus.o_busy), 64'h0);
      check("mthi_val", 64'(bus.o_hi), 64'h1234);
      check("mtlo_val", 64'(bus.o_lo), 64'h5678);

      // Busy from the accept edge; HI/LO untouched while running.
      issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      check("busy_at_accept", 64'(bus.o_busy), 64'h1);
      repeat (15) @(negedge clk);
      check("run_hi_hold", 64'(bus.o_hi), 64'h1234);
      check("run_lo_hold", 64'(bus.o_lo), 64'h5678);
      wait_idle();

      run(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
      run(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run(OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
      run(OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
      run(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
      run(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

      // Reserved op is ignored.
      issue(OP_RSV, 32'h1111_1111, 32'h2222_2222, 1'b0, '0, '0);
      check("rsv_busy", 64'(bus.o_busy), 64'h0);
      check("rsv_hi", 64'(bus.o_hi), 64'h0);
      check("rsv_lo", 64'(bus.o_lo), 64'h8000_0000);

      // Start while busy is dropped; only the first result and one Done.
      issue(OP_MULTU, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'h0, 32'h0000_000F);
      issue(OP_DIVU,  32'h0000_0064, 32'h0000_0007, 1'b0, '0, '0);
      wait_idle();

      // Abort and Start together in IDLE: Start wins.
      bus.i_abort = 1'b1;
      issue(OP_MULTU, 32'h0000_0006, 32'h0000_0007, 1'b1, 32'h0, 32'h0000_002A);
      bus.i_abort = 1'b0;
      wait_idle();

      // Abort mid-run: no Done, HI/LO keep MTHI/MTLO values.
      issue(OP_MTHI, 32'h0000_1234, '0, 1'b0, '0, '0);
      issue(OP_MTLO, 32'h0000_5678, '0, 1'b0, '0, '0);
      issue(OP_MULTU, 32'h0000_0009, 32'h0000_0009, 1'b0, '0, '0);
      repeat (9) @(negedge clk);
      bus.i_abort = 1'b1;
      @(posedge clk);
      #1;
      bus.i_abort = 1'b0;
      check("abort_busy", 64'(bus.o_busy), 64'h0);
      repeat (40) @(negedge clk);
      check("abort_hi", 64'(bus.o_hi), 64'h1234);
      check("abort_lo", 64'(bus.o_lo), 64'h5678);

      // Abort on the writeback edge suppresses writeback and Done.
      issue(OP_MULTU, 32'h0000_0009, 32'h0000_0009, 1'b0, '0, '0);
      repeat (N + 1) @(negedge clk);
      bus.i_abort = 1'b1;
      @(posedge clk);
      #1;
      bus.i_abort = 1'b0;
      check("fixabort_busy", 64'(bus.o_busy), 64'h0);
      repeat (5) @(negedge clk);
      check("fixabort_lo", 64'(bus.o_lo), 64'h5678);

      // Reset mid-run discards the operation.
      issue(OP_MULTU, 32'h0000_0009, 32'h0000_0009, 1'b0, '0, '0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_hi", 64'(bus.o_hi), 64'h0);
      check("midrst_lo", 64'(bus.o_lo), 64'h0);
      check("midrst_busy", 64'(bus.o_busy), 64'h0);
      repeat (40) @(negedge clk);
      run(OP_MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F);

      repeat (5) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
